// File: rtl/conv_div_32s_16ns_32_seq.sv
// Sequential signed-by-unsigned restoring divider, one quotient bit per cycle.
// Operands and results move over valid/ready handshakes; one operation in flight.
module conv_div_32s_16ns_32_seq #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic        [DIVISOR_W-1:0]  divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DIVIDEND_W-1:0] quotient,
  output logic signed [DIVISOR_W:0]    remainder,
  output logic                         div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W) + 1;
  localparam int REM_W = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [DIVIDEND_W-1:0]   mag_r;
  logic [DIVISOR_W-1:0]    dsr_r;
  logic [REM_W-1:0]        prem_r;
  logic                    neg_r;
  logic                    dz_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [DIVIDEND_W-1:0]   quotient_r;
  logic [REM_W-1:0]        remainder_r;
  logic                    div_by_zero_r;

  logic [DIVIDEND_W-1:0]   abs_s;
  logic [REM_W-1:0]        shifted_s;
  logic [REM_W:0]          trial_s;
  logic                    last_s;

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

  // Operand magnitude and one restoring step of the partial remainder.
  always_comb begin
    abs_s     = {DIVIDEND_W{1'b0}};
    shifted_s = {REM_W{1'b0}};
    trial_s   = {(REM_W+1){1'b0}};
    last_s    = 1'b0;
    if (dividend[DIVIDEND_W-1]) begin
      // -2^(W-1) wraps onto itself, which is the correct unsigned magnitude
      abs_s = {DIVIDEND_W{1'b0}} - dividend;
    end else begin
      abs_s = dividend;
    end
    // partial remainder is always below the divisor, so its top bit is free
    shifted_s = {prem_r[DIVISOR_W-1:0], mag_r[DIVIDEND_W-1]};
    trial_s   = {1'b0, shifted_s} - {2'b00, dsr_r};
    last_s    = (cnt_r == CNT_W'(DIVIDEND_W - 1));
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r       <= IDLE;
      mag_r         <= {DIVIDEND_W{1'b0}};
      dsr_r         <= {DIVISOR_W{1'b0}};
      prem_r        <= {REM_W{1'b0}};
      neg_r         <= 1'b0;
      dz_r          <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      quotient_r    <= {DIVIDEND_W{1'b0}};
      remainder_r   <= {REM_W{1'b0}};
      div_by_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            mag_r      <= abs_s;
            dsr_r      <= divisor;
            neg_r      <= dividend[DIVIDEND_W-1];
            dz_r       <= (divisor == {DIVISOR_W{1'b0}});
            prem_r     <= {REM_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= (divisor == {DIVISOR_W{1'b0}}) ? FIX : CALC;
          end
        end
        CALC: begin
          // quotient bits shift into the vacated low end of the magnitude
          mag_r <= {mag_r[DIVIDEND_W-2:0], ~trial_s[REM_W]};
          if (trial_s[REM_W]) begin
            prem_r <= shifted_s;
          end else begin
            prem_r <= trial_s[REM_W-1:0];
          end
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_s) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          if (dz_r) begin
            quotient_r    <= neg_r ? {1'b1, {(DIVIDEND_W-1){1'b0}}}
                                   : {1'b0, {(DIVIDEND_W-1){1'b1}}};
            remainder_r   <= {REM_W{1'b0}};
            div_by_zero_r <= 1'b1;
          end else begin
            quotient_r    <= neg_r ? ({DIVIDEND_W{1'b0}} - mag_r) : mag_r;
            remainder_r   <= neg_r ? ({REM_W{1'b0}} - prem_r) : prem_r;
            div_by_zero_r <= 1'b0;
          end
          out_valid_r <= 1'b1;
          state_r     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_div_32s_16ns_32_seq.sv
// Bench for the sequential divider: directed vector table, backpressure, mid-operation
// reset and randomized operands against a truncating-division reference model.
module tb_conv_div_32s_16ns_32_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [16:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 ap_clk = ~ap_clk;

  conv_div_32s_16ns_32_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic [16:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Truncating signed / unsigned division with the divide-by-zero saturation rule.
  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [31:0] q, output logic [16:0] r, output logic dz);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'(b);
    if (b == 16'd0) begin
      q  = (sa >= 64'sd0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      r  = 17'd0;
      dz = 1'b1;
    end else begin
      q  = 32'(sa / sb);
      r  = 17'(sa % sb);
      dz = 1'b0;
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge with the DUT idle.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int stall,
                        input bit early, output logic [31:0] q, output logic [16:0] r,
                        output logic dz, output int lat);
    bit ok;
    chk("in_ready_before_op", 64'(in_ready), 64'd1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = early;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    lat = 1;
    ok  = 1'b0;
    while (lat < 100) begin
      @(negedge ap_clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge ap_clk);
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    chk("out_valid_timeout", 64'(ok), 64'd1);
    chk("in_ready_in_out", 64'(in_ready), 64'd0);
    if (!early) begin
      for (int s = 0; s < stall; s++) begin
        @(posedge ap_clk);
        @(negedge ap_clk);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_stable", {quotient, remainder, div_by_zero}, {q, r, dz});
      end
    end
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    @(negedge ap_clk);
    chk("post_out_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] q;
    logic [16:0] r;
    logic        dz;
    int          lat;
    logic [31:0] eq;
    logic [16:0] er;
    logic        edz;
    logic [31:0] ra;
    logic [15:0] rb;
    int          mode;
    int          seen;

    vecs[0]  = '{32'd100,         16'd7,      32'd14,          17'd2,       1'b0};
    vecs[1]  = '{32'hFFFF_FF9C,   16'd7,      32'hFFFF_FFF2,   17'h1FFFE,   1'b0};
    vecs[2]  = '{32'h8000_0000,   16'd1,      32'h8000_0000,   17'd0,       1'b0};
    vecs[3]  = '{32'h7FFF_FFFF,   16'hFFFF,   32'd32768,       17'd32767,   1'b0};
    vecs[4]  = '{32'd5,           16'd0,      32'h7FFF_FFFF,   17'd0,       1'b1};
    vecs[5]  = '{32'hFFFF_FFFB,   16'd0,      32'h8000_0000,   17'd0,       1'b1};
    vecs[6]  = '{32'd0,           16'd5,      32'd0,           17'd0,       1'b0};
    vecs[7]  = '{32'hFFFF_FFFF,   16'hFFFF,   32'd0,           17'h1FFFF,   1'b0};
    vecs[8]  = '{32'h8000_0000,   16'hFFFF,   32'hFFFF_8000,   17'h18000,   1'b0};
    vecs[9]  = '{32'h7FFF_FFFF,   16'd1,      32'h7FFF_FFFF,   17'd0,       1'b0};
    vecs[10] = '{32'd0,           16'd0,      32'h7FFF_FFFF,   17'd0,       1'b1};

    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 32'd0;
    divisor   = 16'd0;
    repeat (3) @(negedge ap_clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_results", {quotient, remainder, div_by_zero}, 64'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Directed table; entry 0 also carries the long backpressure hold.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, (i == 0) ? 10 : (i % 3), (i == 6), q, r, dz, lat);
      chk($sformatf("vec%0d_quotient", i), 64'(q), 64'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), 64'(r), 64'(vecs[i].r));
      chk($sformatf("vec%0d_dbz", i), 64'(dz), 64'(vecs[i].dz));
      chk($sformatf("vec%0d_latency", i), 64'(lat), (vecs[i].b == 16'd0) ? 64'd2 : 64'd34);
    end

    // Asynchronous reset in the middle of CALC discards the operation.
    dividend = 32'd123456;
    divisor  = 16'd3;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_results", {quotient, remainder, div_by_zero}, 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge ap_clk);
      if (out_valid) seen++;
    end
    chk("midreset_no_out_valid", 64'(seen), 64'd0);
    run_op(32'd1000, 16'd10, 0, 1'b0, q, r, dz, lat);
    chk("after_reset_quotient", 64'(q), 64'd100);
    chk("after_reset_remainder", 64'(r), 64'd0);

    // Randomized regression against the reference model.
    for (int n = 0; n < 1200; n++) begin
      mode = $urandom_range(0, 9);
      ra   = $urandom;
      rb   = 16'($urandom);
      case (mode)
        0: rb = 16'd1;
        1: rb = 16'hFFFF;
        2: ra = 32'd0;
        3: rb = 16'd0;
        4: ra = 32'h8000_0000;
        5: rb = 16'($urandom_range(1, 15));
        default: ;
      endcase
      model(ra, rb, eq, er, edz);
      run_op(ra, rb, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), q, r, dz, lat);
      chk($sformatf("rand%0d_q %0h/%0h", n, ra, rb), 64'(q), 64'(eq));
      chk($sformatf("rand%0d_r %0h/%0h", n, ra, rb), 64'(r), 64'(er));
      chk($sformatf("rand%0d_dbz", n), 64'(dz), 64'(edz));
      chk($sformatf("rand%0d_latency", n), 64'(lat), (rb == 16'd0) ? 64'd2 : 64'd34);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
